// File: rtl/fifo_16x8_pkg.sv
// Shared sizing constants and types for the 16x8 synchronous FIFO.
package fifo_16x8_pkg;
  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;

  typedef logic [FIFO_WIDTH-1:0] word_t;
  // One extra MSB beyond the index acts as the wrap bit.
  typedef logic [FIFO_ADDR_W:0]  ptr_t;
endpackage

// File: rtl/fifo_16x8_if.sv
// Producer/consumer bus of the 16x8 FIFO. Error pulses exist only with FIFO16X8_ERR_EN.
interface fifo_16x8_if;
  import fifo_16x8_pkg::*;

  logic  we;
  logic  re;
  word_t wr_data;
  word_t data;
  logic  full;
  logic  empty;
`ifdef FIFO16X8_ERR_EN
  logic  overflow;
  logic  underflow;
`endif

  modport master (
    output we, re, wr_data,
`ifdef FIFO16X8_ERR_EN
    input  overflow, underflow,
`endif
    input  data, full, empty
  );

  modport slave (
    input  we, re, wr_data,
`ifdef FIFO16X8_ERR_EN
    output overflow, underflow,
`endif
    output data, full, empty
  );
endinterface

// File: rtl/fifo_16x8_mem.sv
// Storage array with one write port and one registered read port.
// The read register is the FIFO data output, hence its asynchronous reset.
module fifo_16x8_mem
  import fifo_16x8_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Contents are intentionally left unreset so the array maps to RAM.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fifo_16x8.sv
// 16-deep, 8-bit synchronous FIFO with full/empty flags and registered read data.
// Define FIFO16X8_ERR_EN to add registered overflow/underflow pulses.
module fifo_16x8
  import fifo_16x8_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic       clock,
  input  logic       reset,
  fifo_16x8_if.slave bus
);
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic full;
  logic empty;
  logic wr_accept;
  logic rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Each side is judged against the flags from before the edge.
  assign wr_accept = bus.we && !full;
  assign rd_accept = bus.re && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_16x8_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (bus.data)
  );

  assign bus.full  = full;
  assign bus.empty = empty;

`ifdef FIFO16X8_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = bus.we && full;
    underflow_d = bus.re && empty;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_16x8.sv
// Directed self-checking bench for fifo_16x8; covers the error pulses when
// FIFO16X8_ERR_EN is defined for the build.
module tb_fifo_16x8;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  fifo_16x8_if ifc ();

  fifo_16x8 dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Applies one cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    ifc.we      = w;
    ifc.re      = r;
    ifc.wr_data = d;
    @(posedge clock);
    #1;
    ifc.we = 1'b0;
    ifc.re = 1'b0;
    $display("txn we=%0b re=%0b wr_data=%02h -> data=%02h full=%0b empty=%0b",
             w, r, d, ifc.data, ifc.full, ifc.empty);
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b1, 8'h00}) begin
      $display("FAIL reset_async full/empty/data got=%b/%b/%02h want=0/1/00",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i + 1));
      checks++;
      if ({ifc.full, ifc.empty} !== {(i == 15), 1'b0}) begin
        $display("FAIL fill_flags[%0d] full/empty got=%b/%b want=%b/0",
                 i, ifc.full, ifc.empty, (i == 15));
        failures++;
      end
    end
    step(1'b1, 1'b0, 8'hAA);
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b1, 1'b0, 8'h00}) begin
      $display("FAIL fill_overwrite full/empty/data got=%b/%b/%02h want=1/0/00",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
`ifdef FIFO16X8_ERR_EN
    checks++;
    if (ifc.overflow !== 1'b1) begin
      $display("FAIL overflow_pulse got=%b want=1", ifc.overflow);
      failures++;
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (ifc.overflow !== 1'b0) begin
      $display("FAIL overflow_clear got=%b want=0", ifc.overflow);
      failures++;
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, (i == 15), 8'(i + 1)}) begin
        $display("FAIL drain[%0d] full/empty/data got=%b/%b/%02h want=0/%b/%02h",
                 i, ifc.full, ifc.empty, ifc.data, (i == 15), 8'(i + 1));
        failures++;
      end
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b1, 8'h10}) begin
      $display("FAIL drain_underread full/empty/data got=%b/%b/%02h want=0/1/10",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
`ifdef FIFO16X8_ERR_EN
    checks++;
    if (ifc.underflow !== 1'b1) begin
      $display("FAIL underflow_pulse got=%b want=1", ifc.underflow);
      failures++;
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (ifc.underflow !== 1'b0) begin
      $display("FAIL underflow_clear got=%b want=0", ifc.underflow);
      failures++;
    end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({ifc.empty, ifc.data} !== {(i == 9), 8'(8'h20 + i)}) begin
        $display("FAIL wrap_a[%0d] empty/data got=%b/%02h want=%b/%02h",
                 i, ifc.empty, ifc.data, (i == 9), 8'(8'h20 + i));
        failures++;
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i));
      checks++;
      if ({ifc.full, ifc.empty} !== {(i == 15), 1'b0}) begin
        $display("FAIL wrap_fill[%0d] full/empty got=%b/%b want=%b/0",
                 i, ifc.full, ifc.empty, (i == 15));
        failures++;
      end
    end
    // Full with both enables: read accepted, write of EE dropped.
    step(1'b1, 1'b1, 8'hEE);
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b0, 8'h40}) begin
      $display("FAIL wrap_full_both full/empty/data got=%b/%b/%02h want=0/0/40",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({ifc.empty, ifc.data} !== {(i == 15), 8'(8'h40 + i)}) begin
        $display("FAIL wrap_b[%0d] empty/data got=%b/%02h want=%b/%02h",
                 i, ifc.empty, ifc.data, (i == 15), 8'(8'h40 + i));
        failures++;
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'(8'h65 + i));
      checks++;
      if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b0, 8'(8'h60 + i)}) begin
        $display("FAIL simul[%0d] full/empty/data got=%b/%b/%02h want=0/0/%02h",
                 i, ifc.full, ifc.empty, ifc.data, 8'(8'h60 + i));
        failures++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({ifc.empty, ifc.data} !== {(i == 4), 8'(8'h63 + i)}) begin
        $display("FAIL simul_drain[%0d] empty/data got=%b/%02h want=%b/%02h",
                 i, ifc.empty, ifc.data, (i == 4), 8'(8'h63 + i));
        failures++;
      end
    end
    // Empty with both enables: write only, no read-through.
    step(1'b1, 1'b1, 8'h77);
    checks++;
    if ({ifc.empty, ifc.data} !== {1'b0, 8'h67}) begin
      $display("FAIL simul_empty empty/data got=%b/%02h want=0/67", ifc.empty, ifc.data);
      failures++;
    end
`ifdef FIFO16X8_ERR_EN
    checks++;
    if ({ifc.overflow, ifc.underflow} !== 2'b01) begin
      $display("FAIL simul_empty_err ovf/unf got=%b want=01", {ifc.overflow, ifc.underflow});
      failures++;
    end
`endif
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({ifc.empty, ifc.data} !== {1'b1, 8'h77}) begin
      $display("FAIL simul_empty_read empty/data got=%b/%02h want=1/77", ifc.empty, ifc.data);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b0, 1'b1, 8'h00);
    ifc.we      = 1'b1;
    ifc.wr_data = 8'hCC;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b1, 8'h00}) begin
      $display("FAIL reset_mid full/empty/data got=%b/%b/%02h want=0/1/00",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
    ifc.we = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({ifc.full, ifc.empty, ifc.data} !== {1'b0, 1'b1, 8'h55}) begin
      $display("FAIL reset_mid_after full/empty/data got=%b/%b/%02h want=0/1/55",
               ifc.full, ifc.empty, ifc.data);
      failures++;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    ifc.we      = 1'b0;
    ifc.re      = 1'b0;
    ifc.wr_data = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
